dcp_req_scheduler: RTL and testbench
====================================

# dcp_req_scheduler

Shares one outbound DCP request channel among `NUM_REQ` Cohort requesters and owns the MSHR ID pool for that channel. Picks requesters round-robin and allocates a free MSHR ID to each accepted request. Issues requests through a single registered output stage. Returns each response to the requester that owns the response's MSHR ID, then frees that ID. It sits between the per-engine request generators and the DCP NoC encoder. All field types come from `dcp_pkg`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8
- `NUM_MSHR`, 8: MSHR IDs in the pool, 1..2^`DCP_MSHRID_WIDTH`; the usable IDs are 0..NUM_MSHR-1

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `reset_i` in 1: reset, synchronous, active-high
- `req_val_i` in [NUM_REQ]: per-requester request valid
- `req_rdy_o` out [NUM_REQ]: per-requester accept; at most one bit is high
- `req_type_i` in [NUM_REQ] x `req_type_t`: request type
- `req_addr_i` in [NUM_REQ] x `paddr_t`: request address
- `req_size_i` in [NUM_REQ] x `size_t`: request size
- `req_data_i` in [NUM_REQ] x `data_t`: store/AMO data
- `req_mask_i` in [NUM_REQ] x `write_mask_t`: write mask
- `noc_val_o` out 1, `noc_rdy_i` in 1: outbound valid/ready
- `noc_type_o`, `noc_mshrid_o`, `noc_addr_o`, `noc_size_o`, `noc_data_o`, `noc_mask_o` out: registered outbound fields (`mshrid_t` for the ID)
- `resp_val_i` in 1, `resp_rdy_o` out 1: inbound response handshake
- `resp_mshrid_i` in `mshrid_t`, `resp_data_i` in `data_t`: inbound response fields
- `rsp_val_o` out [NUM_REQ], `rsp_rdy_i` in [NUM_REQ]: per-requester response handshake
- `rsp_data_o` out `data_t`: response data, shared by all requesters
- `mshr_busy_o` out [NUM_MSHR]: allocated-ID vector
- `err_o` out 1: sticky protocol-error flag

## Operation
- State:
  - `busy[NUM_MSHR]`
  - `owner[NUM_MSHR]` (clog2 NUM_REQ bits each)
  - round-robin pointer `rr`
  - outbound register with valid bit
  - `err`
- Issue condition, evaluated combinationally each cycle. A slot is available when the outbound register is empty, or `noc_val_o & noc_rdy_i` holds this cycle. Issue when a slot is available, any `req_val_i` is high, and some `busy` bit is 0.
- Grant: the first valid requester at or after `rr`, modulo NUM_REQ. Raise `req_rdy_o[g]` in the same cycle.
- Allocation: the lowest-index ID with `busy`=0, taken from the registered `busy`. An ID freed in the current cycle is not reused until the next cycle.
- On grant, at the next edge:
  - the outbound register loads requester g's fields plus the allocated ID;
  - `busy[id]` ← 1 and `owner[id]` ← g;
  - `rr` ← (g+1) mod NUM_REQ.
- Outbound fields hold stable while `noc_val_o`=1 and `noc_rdy_i`=0.
- Pool full (all `busy`): every `req_rdy_o` is 0. The outbound register still drains.
- Response routing is combinational. With o = `owner[resp_mshrid_i]`:
  - `rsp_val_o[o]` = `resp_val_i & busy[id]`;
  - `rsp_data_o` = `resp_data_i`;
  - `resp_rdy_o` = `rsp_rdy_i[o]`.
- Completed response (`resp_val_i & resp_rdy_o` with `busy[id]`): `busy[id]` ← 0 at the edge.
- Spurious response (`busy[id]`=0, or id ≥ NUM_MSHR):
  - `resp_rdy_o`=1; the flit is consumed and dropped;
  - no `rsp_val_o` is raised;
  - `err` ← 1.
- Same ID freed and allocated in one cycle: impossible by the allocation rule. Another free ID may still be allocated that cycle.

## Timing
- Reset values:
  - `noc_val_o`=0 and all outbound fields 0;
  - `req_rdy_o`=0, `rsp_val_o`=0, `resp_rdy_o`=0 (after reset, `resp_rdy_o` follows the routing rule);
  - `busy`=0, `owner`=0, `rr`=0, `err_o`=0.
- Request latency: a handshake at cycle t gives `noc_val_o`=1 at t+1. Sustained throughput is 1 request/cycle while `noc_rdy_i`=1 and IDs are free.
- Response path: zero latency, combinational, no buffering. `busy` clears at the edge that ends the response handshake.
- `err_o` stays at 1 until `reset_i`.
- Reset mid-operation:
  - in-flight outbound content is discarded;
  - all IDs return to free;
  - responses arriving afterwards to the old IDs are spurious and set `err_o`.

## Test plan
- Single request: `NUM_REQ`=4. Req 2 raises valid with addr 0x1000 at cycle 5, `noc_rdy_i`=1. Required: `req_rdy_o`=4'b0100 at cycle 5; at cycle 6, `noc_val_o`=1, `noc_mshrid_o`=0, `noc_addr_o`=0x1000; `mshr_busy_o`=8'h01.
- Round-robin: all 4 requesters valid continuously, `noc_rdy_i`=1. Required: grant order 0,1,2,3 on consecutive cycles, `noc_mshrid_o` 0,1,2,3 on cycles t+1..t+4.
- Pool exhaustion: 8 requests issue with no responses. Required: `mshr_busy_o`=8'hFF and `req_rdy_o`=0. Then a response with ID 5 is accepted. Required: the next grant, one cycle later, gets ID 5.
- Backpressure: `noc_rdy_i`=0 for 10 cycles while requests are pending. Required: the outbound fields are held constant, and exactly one grant occurs before the stall releases.
- Out-of-order responses: IDs 0 (req 1) and 1 (req 3) are outstanding. Send a response for ID 1 and hold `rsp_rdy_i[3]`=0 for 3 cycles. Required: `resp_rdy_o`=0 during the hold and `busy[1]` stays set; after release, routing goes to req 3. Then the ID 0 response routes to req 1.
- Spurious response and reset: a response for a free ID 6. Required: `resp_rdy_o`=1, no `rsp_val_o`, `err_o`=1 from the next cycle. Then assert `reset_i` while `noc_val_o`=1. Required: on the following cycle `noc_val_o`=0, `mshr_busy_o`=0, `err_o`=0.

Source files
------------

// File: rtl/dcp_pkg.sv
// -----------------------------------------------------------------------------
// dcp_pkg
//   Shared field types for the DCP request/response channel.
//   DCP_MSHRID_WIDTH bounds the MSHR ID pool a scheduler may own.
// -----------------------------------------------------------------------------
package dcp_pkg;

  localparam int DCP_MSHRID_WIDTH = 4;

  typedef logic [2:0]                  req_type_t;
  typedef logic [39:0]                 paddr_t;
  typedef logic [2:0]                  size_t;
  typedef logic [63:0]                 data_t;
  typedef logic [7:0]                  write_mask_t;
  typedef logic [DCP_MSHRID_WIDTH-1:0] mshrid_t;

  // One request as carried by the outbound stage.
  typedef struct packed {
    req_type_t   rtype;
    paddr_t      addr;
    size_t       size;
    data_t       data;
    write_mask_t mask;
  } dcp_req_t;

endpackage

// File: rtl/dcp_req_scheduler_if.sv
// -----------------------------------------------------------------------------
// dcp_req_scheduler_if
//   Bundles every handshake/bus signal of dcp_req_scheduler.
//   Groups:
//     req_*  : NUM_REQ requester ports (valid/ready + request fields)
//     noc_*  : registered outbound DCP request (valid/ready + fields)
//     resp_* : inbound DCP response (valid/ready + MSHR ID + data)
//     rsp_*  : per-requester response return (valid/ready, shared data)
//     mshr_busy_o, err_o : pool status and sticky protocol error
//   Modports:
//     slave  : the scheduler itself
//     master : the surrounding requesters / NoC
// -----------------------------------------------------------------------------
interface dcp_req_scheduler_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_MSHR = 8
);

  logic [NUM_REQ-1:0]   req_val_i;
  logic [NUM_REQ-1:0]   req_rdy_o;
  dcp_pkg::req_type_t   req_type_i [NUM_REQ];
  dcp_pkg::paddr_t      req_addr_i [NUM_REQ];
  dcp_pkg::size_t       req_size_i [NUM_REQ];
  dcp_pkg::data_t       req_data_i [NUM_REQ];
  dcp_pkg::write_mask_t req_mask_i [NUM_REQ];

  logic                 noc_val_o;
  logic                 noc_rdy_i;
  dcp_pkg::req_type_t   noc_type_o;
  dcp_pkg::mshrid_t     noc_mshrid_o;
  dcp_pkg::paddr_t      noc_addr_o;
  dcp_pkg::size_t       noc_size_o;
  dcp_pkg::data_t       noc_data_o;
  dcp_pkg::write_mask_t noc_mask_o;

  logic                 resp_val_i;
  logic                 resp_rdy_o;
  dcp_pkg::mshrid_t     resp_mshrid_i;
  dcp_pkg::data_t       resp_data_i;

  logic [NUM_REQ-1:0]   rsp_val_o;
  logic [NUM_REQ-1:0]   rsp_rdy_i;
  dcp_pkg::data_t       rsp_data_o;

  logic [NUM_MSHR-1:0]  mshr_busy_o;
  logic                 err_o;

  modport slave (
    input  req_val_i, req_type_i, req_addr_i, req_size_i, req_data_i, req_mask_i,
    output req_rdy_o,
    output noc_val_o, noc_type_o, noc_mshrid_o, noc_addr_o, noc_size_o, noc_data_o, noc_mask_o,
    input  noc_rdy_i,
    input  resp_val_i, resp_mshrid_i, resp_data_i,
    output resp_rdy_o,
    output rsp_val_o, rsp_data_o,
    input  rsp_rdy_i,
    output mshr_busy_o, err_o
  );

  modport master (
    output req_val_i, req_type_i, req_addr_i, req_size_i, req_data_i, req_mask_i,
    input  req_rdy_o,
    input  noc_val_o, noc_type_o, noc_mshrid_o, noc_addr_o, noc_size_o, noc_data_o, noc_mask_o,
    output noc_rdy_i,
    output resp_val_i, resp_mshrid_i, resp_data_i,
    input  resp_rdy_o,
    input  rsp_val_o, rsp_data_o,
    output rsp_rdy_i,
    input  mshr_busy_o, err_o
  );

endinterface

// File: rtl/dcp_req_scheduler.sv
// -----------------------------------------------------------------------------
// dcp_req_scheduler
//   Shares one outbound DCP request channel among NUM_REQ requesters and owns
//   the MSHR ID pool for it. Round-robin grant, lowest-free-ID allocation,
//   single registered outbound stage, combinational response return routed
//   by the owner recorded for each MSHR ID.
//   Ports:
//     clk_i   : clock
//     reset_i : synchronous active-high reset
//     bus     : dcp_req_scheduler_if.slave (all request/NoC/response signals)
// -----------------------------------------------------------------------------
module dcp_req_scheduler
  import dcp_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_MSHR = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  dcp_req_scheduler_if.slave bus
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [OW-1:0] req_idx_t;

  // Registered state
  logic [NUM_MSHR-1:0] busy;
  req_idx_t            owner [NUM_MSHR];
  req_idx_t            rr;
  logic                out_val;
  dcp_req_t            out_req;
  mshrid_t             out_id;
  logic                err;

  // Combinational decisions
  logic     slot_avail;
  logic     issue;
  logic     gnt_found;
  req_idx_t gnt_idx;
  req_idx_t cand;
  mshrid_t  alloc_id;
  logic     resp_hit;
  req_idx_t resp_owner;
  logic     resp_fire;
  logic     resp_spurious;

  // Round-robin search: first valid requester at or after rr.
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = req_idx_t'((int'(rr) + k) % NUM_REQ);
      if (!gnt_found && bus.req_val_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Lowest free ID from the registered busy vector; an ID freed this cycle
  // is still busy here, so it cannot be handed out again until next cycle.
  always_comb begin
    alloc_id = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_id = mshrid_t'(i);
    end
  end

  assign slot_avail = !out_val || bus.noc_rdy_i;
  assign issue      = !reset_i && slot_avail && gnt_found && !(&busy);

  always_comb begin
    bus.req_rdy_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (issue && int'(gnt_idx) == r) bus.req_rdy_o[r] = 1'b1;
    end
  end

  // Response lookup; IDs outside the pool never hit.
  always_comb begin
    resp_hit   = 1'b0;
    resp_owner = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (int'(bus.resp_mshrid_i) == i) begin
        resp_hit   = busy[i];
        resp_owner = owner[i];
      end
    end
  end

  // Spurious responses are always accepted so the NoC never wedges on them.
  assign bus.resp_rdy_o = !reset_i && (resp_hit ? bus.rsp_rdy_i[resp_owner] : 1'b1);
  assign bus.rsp_data_o = bus.resp_data_i;
  assign resp_fire      = bus.resp_val_i && resp_hit && bus.rsp_rdy_i[resp_owner];
  assign resp_spurious  = bus.resp_val_i && !resp_hit;

  always_comb begin
    bus.rsp_val_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!reset_i && bus.resp_val_i && resp_hit && int'(resp_owner) == r) bus.rsp_val_o[r] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy    <= '0;
      rr      <= '0;
      out_val <= 1'b0;
      out_req <= '0;
      out_id  <= '0;
      err     <= 1'b0;
      // NOTE: the owner table is only NUM_MSHR tiny entries, so it is reset
      // like ordinary flops to keep post-reset state fully defined.
      for (int i = 0; i < NUM_MSHR; i++) owner[i] <= '0;
    end else begin
      if (out_val && bus.noc_rdy_i) out_val <= 1'b0;

      if (issue) begin
        out_val       <= 1'b1;
        out_req.rtype <= bus.req_type_i[gnt_idx];
        out_req.addr  <= bus.req_addr_i[gnt_idx];
        out_req.size  <= bus.req_size_i[gnt_idx];
        out_req.data  <= bus.req_data_i[gnt_idx];
        out_req.mask  <= bus.req_mask_i[gnt_idx];
        out_id        <= alloc_id;
        rr            <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + req_idx_t'(1);
      end

      // Allocated and freed IDs never coincide: alloc_id is free, a freed ID is busy.
      for (int i = 0; i < NUM_MSHR; i++) begin
        if (issue && int'(alloc_id) == i) begin
          busy[i]  <= 1'b1;
          owner[i] <= gnt_idx;
        end
        if (resp_fire && int'(bus.resp_mshrid_i) == i) busy[i] <= 1'b0;
      end

      if (resp_spurious) err <= 1'b1;
    end
  end

  assign bus.noc_val_o    = out_val;
  assign bus.noc_type_o   = out_req.rtype;
  assign bus.noc_mshrid_o = out_id;
  assign bus.noc_addr_o   = out_req.addr;
  assign bus.noc_size_o   = out_req.size;
  assign bus.noc_data_o   = out_req.data;
  assign bus.noc_mask_o   = out_req.mask;
  assign bus.mshr_busy_o  = busy;
  assign bus.err_o        = err;

endmodule

// File: tb/tb_dcp_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dcp_req_scheduler
//   Directed scenarios followed by randomized traffic, all compared each cycle
//   against a behavioural model of the scheduler built from plain arrays.
// -----------------------------------------------------------------------------
module tb_dcp_req_scheduler;
  import dcp_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int NUM_MSHR = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   dut_grants  = 0;
  int   obs_grant   = -1;

  always #5 clk = ~clk;

  dcp_req_scheduler_if #(.NUM_REQ(NUM_REQ), .NUM_MSHR(NUM_MSHR)) bus ();

  dcp_req_scheduler #(.NUM_REQ(NUM_REQ), .NUM_MSHR(NUM_MSHR)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  // Reference model state
  bit       m_busy  [NUM_MSHR];
  int       m_owner [NUM_MSHR];
  int       m_rr;
  bit       m_oval;
  dcp_req_t m_out;
  int       m_id;
  bit       m_err;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_MSHR; i++) begin
      m_busy[i]  = 1'b0;
      m_owner[i] = 0;
    end
    m_rr = 0; m_oval = 1'b0; m_out = '0; m_id = 0; m_err = 1'b0;
  endtask

  task automatic randomize_fields();
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_type_i[r] = req_type_t'($urandom);
      bus.req_addr_i[r] = paddr_t'({$urandom, $urandom});
      bus.req_size_i[r] = size_t'($urandom);
      bus.req_data_i[r] = {$urandom, $urandom};
      bus.req_mask_i[r] = write_mask_t'($urandom);
    end
  endtask

  task automatic clear_inputs();
    bus.req_val_i     = '0;
    bus.noc_rdy_i     = 1'b1;
    bus.resp_val_i    = 1'b0;
    bus.resp_mshrid_i = '0;
    bus.resp_data_i   = '0;
    bus.rsp_rdy_i     = '1;
    randomize_fields();
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Compare this cycle's outputs against the model, then advance the model
  // by the edge that follows.
  task automatic eval();
    int g, alloc, id, o;
    bit issue, hit, e_resp_rdy;
    logic [NUM_REQ-1:0]  e_req_rdy, e_rsp_val;
    logic [NUM_MSHR-1:0] e_busy;
    #1;
    obs_grant = -1;
    for (int r = 0; r < NUM_REQ; r++) if (bus.req_rdy_o[r]) obs_grant = r;
    if (bus.req_rdy_o != '0) dut_grants++;
    for (int i = 0; i < NUM_MSHR; i++) e_busy[i] = m_busy[i];

    check("noc_val",    64'(bus.noc_val_o),    64'(m_oval));
    check("noc_type",   64'(bus.noc_type_o),   64'(m_out.rtype));
    check("noc_mshrid", 64'(bus.noc_mshrid_o), 64'(m_id));
    check("noc_addr",   64'(bus.noc_addr_o),   64'(m_out.addr));
    check("noc_size",   64'(bus.noc_size_o),   64'(m_out.size));
    check("noc_data",   bus.noc_data_o,        m_out.data);
    check("noc_mask",   64'(bus.noc_mask_o),   64'(m_out.mask));
    check("mshr_busy",  64'(bus.mshr_busy_o),  64'(e_busy));
    check("err",        64'(bus.err_o),        64'(m_err));
    check("rsp_data",   bus.rsp_data_o,        bus.resp_data_i);

    if (reset) begin
      check("req_rdy_rst",  64'(bus.req_rdy_o),  64'(0));
      check("rsp_val_rst",  64'(bus.rsp_val_o),  64'(0));
      check("resp_rdy_rst", 64'(bus.resp_rdy_o), 64'(0));
      model_reset();
      return;
    end

    // Round-robin winner and lowest free ID.
    g = -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (g < 0 && bus.req_val_i[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
    alloc = -1;
    for (int i = 0; i < NUM_MSHR; i++) if (alloc < 0 && !m_busy[i]) alloc = i;
    issue     = (g >= 0) && (alloc >= 0) && (!m_oval || bus.noc_rdy_i);
    e_req_rdy = issue ? NUM_REQ'(1 << g) : '0;

    id  = int'(bus.resp_mshrid_i);
    hit = (id < NUM_MSHR) ? m_busy[id] : 1'b0;
    o   = hit ? m_owner[id] : 0;
    e_resp_rdy = hit ? bus.rsp_rdy_i[o] : 1'b1;
    e_rsp_val  = (bus.resp_val_i && hit) ? NUM_REQ'(1 << o) : '0;

    check("req_rdy",  64'(bus.req_rdy_o),  64'(e_req_rdy));
    check("resp_rdy", 64'(bus.resp_rdy_o), 64'(e_resp_rdy));
    check("rsp_val",  64'(bus.rsp_val_o),  64'(e_rsp_val));

    if (m_oval && bus.noc_rdy_i) m_oval = 1'b0;
    if (bus.resp_val_i && hit && e_resp_rdy) m_busy[id] = 1'b0;
    if (bus.resp_val_i && !hit) m_err = 1'b1;
    if (issue) begin
      m_oval       = 1'b1;
      m_out.rtype  = bus.req_type_i[g];
      m_out.addr   = bus.req_addr_i[g];
      m_out.size   = bus.req_size_i[g];
      m_out.data   = bus.req_data_i[g];
      m_out.mask   = bus.req_mask_i[g];
      m_id         = alloc;
      m_busy[alloc]  = 1'b1;
      m_owner[alloc] = g;
      m_rr         = (g + 1) % NUM_REQ;
    end
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1; clear_inputs(); eval();
    tick(); reset = 1'b0; eval();
  endtask

  task automatic random_drive();
    int busy_ids [$];
    reset         = ($urandom_range(0, 299) == 0);
    bus.req_val_i = NUM_REQ'($urandom);
    randomize_fields();
    bus.noc_rdy_i   = ($urandom_range(0, 3) != 0);
    bus.resp_val_i  = ($urandom_range(0, 2) == 0);
    bus.resp_data_i = {$urandom, $urandom};
    bus.rsp_rdy_i   = NUM_REQ'($urandom);
    for (int i = 0; i < NUM_MSHR; i++) if (m_busy[i]) busy_ids.push_back(i);
    if (busy_ids.size() > 0 && $urandom_range(0, 9) != 0)
      bus.resp_mshrid_i = mshrid_t'(busy_ids[$urandom_range(0, busy_ids.size() - 1)]);
    else
      bus.resp_mshrid_i = mshrid_t'($urandom);
  endtask

  logic [39:0] held_addr;
  logic [63:0] held_data;
  logic [3:0]  held_id;
  int          grants_before;

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;

    // Reset state, then idle cycles.
    tick(); eval();
    tick(); reset = 1'b0; eval();
    repeat (3) begin tick(); eval(); end

    // Single request from requester 2.
    tick(); bus.req_val_i = 4'b0100; bus.req_addr_i[2] = 40'h1000; eval();
    check("single_rdy", 64'(bus.req_rdy_o), 64'h4);
    tick(); bus.req_val_i = '0; eval();
    check("single_val",  64'(bus.noc_val_o),    64'h1);
    check("single_id",   64'(bus.noc_mshrid_o), 64'h0);
    check("single_addr", 64'(bus.noc_addr_o),   64'h1000);
    check("single_busy", 64'(bus.mshr_busy_o),  64'h01);

    // Round-robin with all requesters valid, continuing into pool exhaustion.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick(); bus.req_val_i = '1; randomize_fields(); eval();
      check("rr_grant", 64'(obs_grant), 64'(k % NUM_REQ));
      if (k > 0) check("rr_id", 64'(bus.noc_mshrid_o), 64'(k - 1));
    end
    tick(); randomize_fields(); eval();
    check("full_busy", 64'(bus.mshr_busy_o), 64'hFF);
    check("full_rdy",  64'(bus.req_rdy_o),   64'h0);
    check("full_id",   64'(bus.noc_mshrid_o), 64'h7);
    tick(); bus.resp_val_i = 1'b1; bus.resp_mshrid_i = 4'd5; eval();
    check("free5_resp_rdy", 64'(bus.resp_rdy_o), 64'h1);
    check("free5_rsp_val",  64'(bus.rsp_val_o),  64'h2);
    check("free5_no_reuse", 64'(bus.req_rdy_o),  64'h0);
    tick(); bus.resp_val_i = 1'b0; eval();
    check("regrant", 64'(bus.req_rdy_o != '0), 64'h1);
    tick(); bus.req_val_i = '0; eval();
    check("regrant_id", 64'(bus.noc_mshrid_o), 64'h5);

    // Backpressure: ten stalled cycles, one grant, fields held.
    do_reset();
    grants_before = dut_grants;
    for (int i = 0; i < 10; i++) begin
      tick(); bus.req_val_i = '1; bus.noc_rdy_i = 1'b0; randomize_fields(); eval();
      if (i == 1) begin
        held_addr = bus.noc_addr_o; held_data = bus.noc_data_o; held_id = bus.noc_mshrid_o;
      end else if (i > 1) begin
        check("bp_hold_addr", 64'(bus.noc_addr_o),   64'(held_addr));
        check("bp_hold_data", bus.noc_data_o,        held_data);
        check("bp_hold_id",   64'(bus.noc_mshrid_o), 64'(held_id));
      end
    end
    check("bp_grants", 64'(dut_grants - grants_before), 64'h1);
    tick(); bus.noc_rdy_i = 1'b1; eval();
    check("bp_release", 64'(bus.req_rdy_o != '0), 64'h1);

    // Out-of-order responses: ID0 owned by req 1, ID1 by req 3.
    do_reset();
    tick(); bus.req_val_i = 4'b0010; eval();
    tick(); bus.req_val_i = 4'b1000; eval();
    for (int i = 0; i < 3; i++) begin
      tick(); bus.req_val_i = '0; bus.resp_val_i = 1'b1; bus.resp_mshrid_i = 4'd1;
      bus.resp_data_i = 64'hDEAD_BEEF_0000_0001; bus.rsp_rdy_i = 4'b0111; eval();
      check("ooo_hold_rdy",  64'(bus.resp_rdy_o),     64'h0);
      check("ooo_hold_busy", 64'(bus.mshr_busy_o[1]), 64'h1);
      check("ooo_hold_val",  64'(bus.rsp_val_o),      64'h8);
    end
    tick(); bus.rsp_rdy_i = '1; eval();
    check("ooo_id1_rdy", 64'(bus.resp_rdy_o), 64'h1);
    check("ooo_id1_val", 64'(bus.rsp_val_o),  64'h8);
    tick(); bus.resp_mshrid_i = 4'd0; eval();
    check("ooo_id0_val", 64'(bus.rsp_val_o),   64'h2);
    check("ooo_id1_freed", 64'(bus.mshr_busy_o), 64'h01);
    tick(); bus.resp_val_i = 1'b0; eval();
    check("ooo_all_free", 64'(bus.mshr_busy_o), 64'h00);

    // Spurious response to free ID 6, then reset with outbound content live.
    tick(); bus.resp_val_i = 1'b1; bus.resp_mshrid_i = 4'd6; eval();
    check("spur_rdy", 64'(bus.resp_rdy_o), 64'h1);
    check("spur_val", 64'(bus.rsp_val_o),  64'h0);
    tick(); bus.resp_val_i = 1'b0; eval();
    check("spur_err", 64'(bus.err_o), 64'h1);
    tick(); bus.noc_rdy_i = 1'b0; bus.req_val_i = 4'b0001; eval();
    tick(); bus.req_val_i = '0; eval();
    check("pre_rst_val", 64'(bus.noc_val_o), 64'h1);
    tick(); reset = 1'b1; eval();
    tick(); reset = 1'b0; eval();
    check("rst_val",  64'(bus.noc_val_o),   64'h0);
    check("rst_busy", 64'(bus.mshr_busy_o), 64'h0);
    check("rst_err",  64'(bus.err_o),       64'h0);
    tick(); bus.resp_val_i = 1'b1; bus.resp_mshrid_i = 4'd0; eval();
    check("stale_val", 64'(bus.rsp_val_o), 64'h0);
    tick(); bus.resp_val_i = 1'b0; eval();
    check("stale_err", 64'(bus.err_o), 64'h1);

    // Randomized traffic against the model.
    do_reset();
    repeat (3000) begin
      tick(); random_drive(); eval();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
